seg_digit_scanner: RTL and testbench

Time-multiplexed scan controller for a multi-digit common-anode 7-segment display. It sits directly upstream of BCD_to_7seg and drives that decoder's 4-bit bcd input with one digit at a time. It also drives the digit anode enables, with configurable refresh rate, inter-digit ghosting gap, tear-free load and leading-zero blanking.

---
 rtl/seg_digit_scanner_pkg.sv | 27 ++
 rtl/seg_digit_scanner_if.sv | 37 +++
 rtl/seg_digit_scanner_prescaler.sv | 36 +++
 rtl/seg_digit_scanner.sv | 129 ++++++++++++
 tb/tb_seg_digit_scanner.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/seg_digit_scanner_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg : shared definitions for the multiplexed 7-segment scan controller.
//   BCD_W      width of one BCD digit code
//   SEG_W      segment count of the downstream BCD_to_7seg decoder
//   ANODE_OFF  all-anodes-off pattern (active-low), sliced to NUM_DIGITS
//   digits_w() packed width of an N-digit BCD vector
//   idx_w()    width of a digit index for N digits (at least 1 bit)
// -----------------------------------------------------------------------------
package seg_pkg;

   localparam int BCD_W = 4;
   localparam int SEG_W = 7;

   // Wide enough for the largest supported display (8 digits).
   localparam logic [7:0] ANODE_OFF = 8'hFF;

   typedef logic [BCD_W-1:0] bcd_t;

   function automatic int digits_w(input int n);
      return n * BCD_W;
   endfunction

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seg_digit_scanner_if.sv
// -----------------------------------------------------------------------------
// seg_digit_scanner_if : load/display bundle of the scan controller.
//   load       in   single-cycle strobe capturing digits_in
//   digits_in  in   packed BCD digits, [3:0] = digit 0 (rightmost)
//   blank_lz   in   leading-zero blanking enable (level)
//   bcd_out    out  BCD code of the digit currently scanned
//   an         out  active-low anode enables
//   digit_idx  out  index of the slot currently scanned
//   load_ack   out  one-cycle acknowledge of a load
// master = the side supplying digits, slave = the scanner.
// -----------------------------------------------------------------------------
interface seg_digit_scanner_if #(
   parameter int NUM_DIGITS = 4
);
   import seg_pkg::*;

   localparam int IDX_W = idx_w(NUM_DIGITS);

   logic                            load;
   logic [digits_w(NUM_DIGITS)-1:0] digits_in;
   logic                            blank_lz;
   logic [BCD_W-1:0]                bcd_out;
   logic [NUM_DIGITS-1:0]           an;
   logic [IDX_W-1:0]                digit_idx;
   logic                            load_ack;

   modport master (
      output load, digits_in, blank_lz,
      input  bcd_out, an, digit_idx, load_ack
   );

   modport slave (
      input  load, digits_in, blank_lz,
      output bcd_out, an, digit_idx, load_ack
   );

endinterface

// File: rtl/seg_digit_scanner_prescaler.sv
// -----------------------------------------------------------------------------
// seg_scan_prescaler : free-running slot timer, counts 0..DIV-1 and wraps.
//   clk         system clock
//   rst_n       asynchronous active-low reset (count returns to 0)
//   count_o     current position inside the digit slot
//   slot_end_o  high in the last cycle of each slot (count == DIV-1)
// -----------------------------------------------------------------------------
module seg_scan_prescaler #(
   parameter int DIV   = 4,
   parameter int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [CNT_W-1:0] count_o,
   output logic             slot_end_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign slot_end_o = (count_q == CNT_W'(DIV - 1));
   assign count_o    = count_q;

   always_comb begin
      count_d = slot_end_o ? '0 : count_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/seg_digit_scanner.sv
// -----------------------------------------------------------------------------
// seg_digit_scanner : time-multiplexed scan controller for a common-anode
// multi-digit 7-segment display, feeding BCD_to_7seg one digit at a time.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of seg_digit_scanner_if (load/digits_in/blank_lz in,
//          bcd_out/an/digit_idx/load_ack out)
// Loads land in a shadow register and are promoted to the displayed digits
// only at the end of a frame, so a frame never mixes old and new digits.
// -----------------------------------------------------------------------------
module seg_digit_scanner
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 100000,
   parameter int GAP_CYCLES  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   seg_digit_scanner_if.slave bus
);

   localparam int IDX_W = idx_w(NUM_DIGITS);
   localparam int DW    = digits_w(NUM_DIGITS);
   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] AN_OFF   = ANODE_OFF[NUM_DIGITS-1:0];

   logic [CNT_W-1:0]      presc;
   logic                  slot_end;
   logic                  frame_end;
   logic                  in_gap;

   logic [IDX_W-1:0]      idx_q,     idx_d;
   logic [DW-1:0]         active_q,  active_d;
   logic [DW-1:0]         shadow_q,  shadow_d;
   logic                  pending_q, pending_d;
   logic [NUM_DIGITS-1:0] an_q,      an_d;
   bcd_t                  bcd_q,     bcd_d;
   logic                  ack_q;

   // zero_from[i]: active digits i..NUM_DIGITS-1 are all zero.
   logic [NUM_DIGITS:1]   zero_from;
   logic [NUM_DIGITS-1:0] blank_vec;

   seg_scan_prescaler #(
      .DIV   (REFRESH_DIV),
      .CNT_W (CNT_W)
   ) u_prescaler (
      .clk        (clk),
      .rst_n      (rst_n),
      .count_o    (presc),
      .slot_end_o (slot_end)
   );

   assign frame_end = slot_end && (idx_q == LAST_IDX);
   assign in_gap    = (GAP_CYCLES > 0) && (int'(presc) < GAP_CYCLES);

   assign zero_from[NUM_DIGITS] = 1'b1;
   // The rightmost digit is never blanked so an all-zero value still shows "0".
   assign blank_vec[0] = 1'b0;

   for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
      assign zero_from[gi] = zero_from[gi+1] && (active_q[gi*BCD_W +: BCD_W] == '0);
      assign blank_vec[gi] = bus.blank_lz && zero_from[gi];
   end

   always_comb begin
      idx_d     = idx_q;
      shadow_d  = shadow_q;
      active_d  = active_q;
      pending_d = pending_q;

      if (slot_end) begin
         idx_d = frame_end ? '0 : idx_q + IDX_W'(1);
      end

      if (bus.load) begin
         shadow_d = bus.digits_in;
      end

      if (frame_end) begin
         // A load coinciding with the frame boundary bypasses the shadow
         // and supersedes any older pending value.
         if (bus.load) begin
            active_d = bus.digits_in;
         end else if (pending_q) begin
            active_d = shadow_q;
         end
         pending_d = 1'b0;
      end else if (bus.load) begin
         pending_d = 1'b1;
      end
   end

   always_comb begin
      an_d  = AN_OFF;
      bcd_d = active_q[idx_q*BCD_W +: BCD_W];
      if (!in_gap && !blank_vec[idx_q]) begin
         an_d[idx_q] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q     <= '0;
         active_q  <= '0;
         shadow_q  <= '0;
         pending_q <= 1'b0;
         an_q      <= AN_OFF;
         bcd_q     <= '0;
         ack_q     <= 1'b0;
      end else begin
         idx_q     <= idx_d;
         active_q  <= active_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         an_q      <= an_d;
         bcd_q     <= bcd_d;
         ack_q     <= bus.load;
      end
   end

   assign bus.an        = an_q;
   assign bus.bcd_out   = bcd_q;
   assign bus.digit_idx = idx_q;
   assign bus.load_ack  = ack_q;

endmodule

// File: tb/tb_seg_digit_scanner.sv
// -----------------------------------------------------------------------------
// tb_seg_digit_scanner : scoreboard bench for seg_digit_scanner with
// NUM_DIGITS=4, REFRESH_DIV=4, GAP_CYCLES=1. cyc counts rising edges since
// reset release; outputs seen after edge k reflect the state after edge k-1,
// so slot d of frame f is sampled at k=16f+4d+3 (lit) and 16f+4d+1 (gap).
// -----------------------------------------------------------------------------
module tb_seg_digit_scanner;

   typedef struct {
      int         k;
      logic [3:0] an;
      logic [3:0] bcd;
      int         idx;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc;
   int   total = 0;
   int   bad   = 0;

   exp_t dq[$];
   int   ackq[$];

   always #5 clk = ~clk;

   seg_digit_scanner_if #(.NUM_DIGITS(4)) bus ();

   seg_digit_scanner #(
      .NUM_DIGITS  (4),
      .REFRESH_DIV (4),
      .GAP_CYCLES  (1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic exp_slot(input int f, input int d, input logic [3:0] an, input logic [3:0] bcd);
      exp_t e;
      e.k = 16*f + 4*d + 3; e.an = an; e.bcd = bcd; e.idx = d;
      dq.push_back(e);
   endtask

   task automatic exp_gap(input int f, input int d, input logic [3:0] bcd);
      exp_t e;
      e.k = 16*f + 4*d + 1; e.an = 4'hF; e.bcd = bcd; e.idx = d;
      dq.push_back(e);
   endtask

   // Display and acknowledge monitor.
   always @(negedge clk) begin
      while (dq.size() > 0 && dq[0].k < cyc) begin
         chk($sformatf("missed_sample_k%0d", dq[0].k), cyc, dq[0].k);
         void'(dq.pop_front());
      end
      if (dq.size() > 0 && dq[0].k == cyc) begin
         $display("sample k=%0d an=%b bcd=%0h idx=%0d", cyc, bus.an, bus.bcd_out, bus.digit_idx);
         chk($sformatf("an_k%0d", cyc),  bus.an,        dq[0].an);
         chk($sformatf("bcd_k%0d", cyc), bus.bcd_out,   dq[0].bcd);
         chk($sformatf("idx_k%0d", cyc), bus.digit_idx, dq[0].idx);
         void'(dq.pop_front());
      end
      while (ackq.size() > 0 && ackq[0] < cyc) begin
         chk($sformatf("missing_ack_k%0d", ackq[0]), 0, 1);
         void'(ackq.pop_front());
      end
      if (bus.load_ack === 1'b1) begin
         $display("ack k=%0d", cyc);
         if (ackq.size() == 0) begin
            chk($sformatf("extra_ack_k%0d", cyc), 1, 0);
         end else begin
            chk("ack_cycle", cyc, ackq[0]);
            void'(ackq.pop_front());
         end
      end
   end

   task automatic wait_cyc(input int n);
      while (cyc < n) begin
         @(negedge clk);
         #1;
      end
   endtask

   // Present a load that is sampled on rising edge number edge_no.
   task automatic do_load(input int edge_no, input logic [15:0] v);
      wait_cyc(edge_no - 1);
      bus.load      = 1'b1;
      bus.digits_in = v;
      ackq.push_back(edge_no);
      @(negedge clk);
      #1;
      bus.load = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n         = 1'b0;
      bus.load      = 1'b0;
      bus.digits_in = '0;
      bus.blank_lz  = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_an",  bus.an,        4'hF);
      chk("rst_bcd", bus.bcd_out,   0);
      chk("rst_idx", bus.digit_idx, 0);
      chk("rst_ack", bus.load_ack,  0);
      rst_n = 1'b1;

      // 1: idle scan after reset.
      for (int d = 0; d < 4; d++) begin
         exp_gap(0, d, 4'h0);
         exp_slot(0, d, ~(4'b0001 << d), 4'h0);
      end
      exp_gap(1, 0, 4'h0);
      exp_slot(1, 0, 4'b1110, 4'h0);

      // 2: mid-frame load only shows from the next frame.
      exp_slot(1, 2, 4'b1011, 4'h0);
      exp_slot(1, 3, 4'b0111, 4'h0);
      exp_slot(2, 0, 4'b1110, 4'h4);
      exp_gap(2, 1, 4'h3);
      exp_slot(2, 1, 4'b1101, 4'h3);
      exp_slot(2, 2, 4'b1011, 4'h2);
      exp_slot(2, 3, 4'b0111, 4'h1);
      do_load(22, 16'h1234);

      // 3: leading-zero blanking.
      exp_slot(3, 0, 4'b1110, 4'h4);
      exp_slot(4, 0, 4'b1110, 4'h0);
      exp_slot(4, 1, 4'b1101, 4'h5);
      exp_slot(4, 2, 4'b1111, 4'h0);
      exp_slot(4, 3, 4'b1111, 4'h0);
      exp_slot(5, 0, 4'b1110, 4'h0);
      exp_slot(5, 1, 4'b1111, 4'h0);
      exp_slot(5, 2, 4'b1111, 4'h0);
      exp_slot(5, 3, 4'b1111, 4'h0);
      wait_cyc(40);
      bus.blank_lz = 1'b1;
      do_load(50, 16'h0050);
      do_load(70, 16'h0000);

      // 4: back-to-back loads, last one wins.
      exp_slot(6, 0, 4'b1110, 4'h0);
      exp_slot(7, 0, 4'b1110, 4'h6);
      exp_slot(7, 1, 4'b1101, 4'h7);
      exp_slot(7, 2, 4'b1011, 4'h8);
      exp_slot(7, 3, 4'b0111, 4'h9);
      do_load(98, 16'h1111);
      do_load(100, 16'h9876);

      // 5: load on the frame_end cycle takes the bypass path.
      exp_slot(8, 3, 4'b0111, 4'h9);
      exp_slot(9, 0, 4'b1110, 4'h1);
      exp_slot(9, 1, 4'b1101, 4'h2);
      do_load(144, 16'h4321);

      // 6: reset mid-slot discards a pending load.
      bus.blank_lz = 1'b0;
      do_load(150, 16'hABCD);
      wait_cyc(153);
      chk("dq_drained_before_rst", dq.size(), 0);
      rst_n = 1'b0;
      #1;
      chk("async_rst_an",  bus.an,        4'hF);
      chk("async_rst_bcd", bus.bcd_out,   0);
      chk("async_rst_idx", bus.digit_idx, 0);
      chk("async_rst_ack", bus.load_ack,  0);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      for (int d = 0; d < 4; d++) exp_slot(0, d, ~(4'b0001 << d), 4'h0);
      for (int d = 0; d < 4; d++) exp_slot(1, d, ~(4'b0001 << d), 4'h0);
      wait_cyc(40);

      chk("dq_empty_at_end",   dq.size(),   0);
      chk("ackq_empty_at_end", ackq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
